// File: rtl/psola_readout_if.sv
// psola_readout_if
//   Bundles everything the PSOLA readout block exchanges with its neighbours:
//     - window start:  window_len_in / window_len_valid_in from the PSOLA stage
//     - BRAM read:     bram_rd_addr -> bram_rd_data (fixed read latency)
//     - BRAM clear:    bram_wr_addr / bram_wr_data / bram_wr_en
//     - PCM stream:    sample_out / sample_valid_out / sample_ready_in
//     - status:        busy_out / done_out / overrun_out
//   modport master: the readout block itself.
//   modport slave:  the surrounding system (PSOLA stage, BRAM, audio path).
interface psola_readout_if #(
  parameter int AW = 12
);
  logic [11:0]        window_len_in;
  logic               window_len_valid_in;
  logic [AW-1:0]      bram_rd_addr;
  logic signed [31:0] bram_rd_data;
  logic [AW-1:0]      bram_wr_addr;
  logic [31:0]        bram_wr_data;
  logic               bram_wr_en;
  logic signed [15:0] sample_out;
  logic               sample_valid_out;
  logic               sample_ready_in;
  logic               busy_out;
  logic               done_out;
  logic               overrun_out;

  modport master (
    input  window_len_in, window_len_valid_in, bram_rd_data, sample_ready_in,
    output bram_rd_addr, bram_wr_addr, bram_wr_data, bram_wr_en,
           sample_out, sample_valid_out, busy_out, done_out, overrun_out
  );

  modport slave (
    output window_len_in, window_len_valid_in, bram_rd_data, sample_ready_in,
    input  bram_rd_addr, bram_wr_addr, bram_wr_data, bram_wr_en,
           sample_out, sample_valid_out, busy_out, done_out, overrun_out
  );
endinterface

// File: rtl/psola_readout.sv
// psola_readout
//   Drains the PSOLA overlap-add accumulation buffer after a window completes.
//   For k = 0 .. len-1 it reads the 32-bit accumulator word, removes the
//   window-function fixed-point gain with an arithmetic right shift, saturates
//   to 16-bit PCM and offers the sample on a valid/ready stream. Once a sample
//   is accepted the same location is written back to zero so the buffer is
//   clean for the next window's accumulation.
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous active-high reset
//   bus     - psola_readout_if.master (window start, BRAM read/clear,
//             PCM stream, busy/done/overrun status)
module psola_readout #(
  parameter int MAX_EXTENDED = 2200,
  parameter int GAIN_SHIFT   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  psola_readout_if.master  bus
);

  localparam int AW  = $clog2(MAX_EXTENDED);
  localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [11:0]    LEN_MAX  = 12'(MAX_EXTENDED);
  localparam logic [WCW-1:0] WCNT_END = WCW'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  // Arithmetic shift: rounds toward negative infinity.
  function automatic logic signed [31:0] remove_gain(input logic signed [31:0] v);
    return v >>> GAIN_SHIFT;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

  state_t             state_q, state_d;
  logic [AW-1:0]      k_q, k_d;
  logic [11:0]        len_q, len_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic [AW-1:0]      rd_addr_q, rd_addr_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic               wr_en_q, wr_en_d;
  logic signed [15:0] sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;

  logic [11:0]        len_clamp;
  logic [AW-1:0]      last_idx;
  logic               busy_now;

  assign len_clamp = (bus.window_len_in > LEN_MAX) ? LEN_MAX : bus.window_len_in;
  assign last_idx  = AW'(len_q - 12'd1);
  // The done cycle is still treated as busy so a start pulse landing there
  // is reported as an overrun rather than silently starting a new window.
  assign busy_now  = (state_q != IDLE) || done_q;

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    len_d          = len_q;
    wcnt_d         = wcnt_q;
    rd_addr_d      = rd_addr_q;
    wr_addr_d      = wr_addr_q;
    wr_en_d        = 1'b0;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    overrun_d      = bus.window_len_valid_in && busy_now;

    case (state_q)
      IDLE: begin
        if (bus.window_len_valid_in && !done_q) begin
          len_d     = len_clamp;
          k_d       = '0;
          rd_addr_d = '0;
          if (len_clamp == 12'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = FETCH;
            busy_d  = 1'b1;
          end
        end
      end

      // bram_rd_addr already holds k on entry; this cycle launches the read.
      FETCH: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end

      WAIT: begin
        if (wcnt_q == WCNT_END) begin
          sample_d       = sat16(remove_gain(bus.bram_rd_data));
          sample_valid_d = 1'b1;
          state_d        = PRESENT;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end

      PRESENT: begin
        if (bus.sample_ready_in) begin
          sample_valid_d = 1'b0;
          wr_en_d        = 1'b1;
          wr_addr_d      = k_q;
          if (k_q == last_idx) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            k_d       = k_q + AW'(1);
            rd_addr_d = k_q + AW'(1);
            state_d   = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      k_q            <= '0;
      len_q          <= '0;
      wcnt_q         <= '0;
      rd_addr_q      <= '0;
      wr_addr_q      <= '0;
      wr_en_q        <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      len_q          <= len_d;
      wcnt_q         <= wcnt_d;
      rd_addr_q      <= rd_addr_d;
      wr_addr_q      <= wr_addr_d;
      wr_en_q        <= wr_en_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.bram_rd_addr     = rd_addr_q;
  assign bus.bram_wr_addr     = wr_addr_q;
  assign bus.bram_wr_data     = 32'd0;
  assign bus.bram_wr_en       = wr_en_q;
  assign bus.sample_out       = sample_q;
  assign bus.sample_valid_out = sample_valid_q;
  assign bus.busy_out         = busy_q;
  assign bus.done_out         = done_q;
  assign bus.overrun_out      = overrun_q;

endmodule

// File: tb/tb_psola_readout.sv
// Testbench for psola_readout: BRAM model with two-cycle read latency, a
// per-cycle stream/clear monitor checked against an arithmetic sample model,
// and directed window scenarios with literal expectations.
module tb_psola_readout;

  localparam int DEPTH = 2200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psola_readout_if #(.AW(12)) bus ();

  psola_readout dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // BRAM model: all writes in one process (bench loads, DUT clears)
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rd_p1;
  logic        ld_en = 1'b0;
  int          ld_addr = 0;
  logic [31:0] ld_data = 32'd0;

  always @(posedge clk) begin
    rd_p1            <= mem[bus.bram_rd_addr];
    bus.bram_rd_data <= rd_p1;
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.bram_wr_en) mem[bus.bram_wr_addr] <= bus.bram_wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // floor(w / 1024) clamped to the signed 16-bit range
  function automatic int model(input logic [31:0] w);
    longint v;
    longint q;
    v = longint'($signed(w));
    q = v / 1024;
    if (v < 0 && (v % 1024) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  // Scoreboard state
  int   exp_q[$];
  int   got_q[$];
  int   cur_len = 0;
  int   wr_idx = 0;
  int   last_wr = -1;
  int   n_samples = 0;
  int   n_done = 0;
  int   n_ovr = 0;
  int   first_vld = -1;
  int   done_cyc = -1;
  int   start_cyc = 0;
  bit   busy_seen = 0;
  bit   chk_en = 0;
  bit   hs_prev = 0;
  bit   prev_hold = 0;
  logic signed [15:0] prev_sample = '0;
  bit   hs;

  always @(negedge clk) begin
    if (!chk_en) begin
      hs_prev   = 0;
      prev_hold = 0;
    end else begin
      chk("wr_data_zero", bus.bram_wr_data, 0);
      chk("clear_after_handshake", bus.bram_wr_en, hs_prev);
      if (bus.bram_wr_en) begin
        chk("clear_addr", bus.bram_wr_addr, wr_idx);
        wr_idx++;
        last_wr = int'(bus.bram_wr_addr);
      end
      if (bus.done_out) begin
        n_done++;
        done_cyc = cyc;
        if (cur_len > 0)
          chk("done_with_last_clear", (bus.bram_wr_en && bus.bram_wr_addr == 12'(cur_len - 1)), 1);
      end
      if (bus.overrun_out) n_ovr++;
      if (bus.busy_out) begin
        busy_seen = 1;
        chk("rd_addr_in_range", (int'(bus.bram_rd_addr) < cur_len), 1);
      end
      if (prev_hold) begin
        chk("hold_valid", bus.sample_valid_out, 1);
        chk("hold_data", bus.sample_out, prev_sample);
      end
      if (bus.sample_valid_out && first_vld < 0) first_vld = cyc;
      hs = bus.sample_valid_out && bus.sample_ready_in;
      if (hs) begin
        if (exp_q.size() == 0) chk("extra_sample", 1, 0);
        else chk("sample", bus.sample_out, exp_q.pop_front());
        got_q.push_back(int'(bus.sample_out));
        n_samples++;
      end
      prev_hold   = bus.sample_valid_out && !bus.sample_ready_in;
      prev_sample = bus.sample_out;
      hs_prev     = hs;
    end
  end

  // Stimulus runs in the phase just after a rising edge.
  task automatic load(input int a, input logic [31:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk); #1;
    ld_en   = 1'b0;
  endtask

  task automatic arm(input int len);
    int nl;
    nl = (len > DEPTH) ? DEPTH : len;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < nl; i++) exp_q.push_back(model(mem[i]));
    cur_len = nl; wr_idx = 0; last_wr = -1; n_samples = 0; n_done = 0;
    n_ovr = 0; first_vld = -1; done_cyc = -1; busy_seen = 0;
    chk_en = 1;
  endtask

  task automatic pulse(input int len);
    bus.window_len_in       = 12'(len);
    bus.window_len_valid_in = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.window_len_valid_in = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int i;
    i = 0;
    while (n_done == 0 && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    if (n_done == 0) chk({nm, "_done_timeout"}, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_done_count"}, n_done, 1);
    chk({nm, "_sample_count"}, n_samples, cur_len);
    chk({nm, "_busy_after"}, bus.busy_out, 0);
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int i;
    i = 0;
    while (!bus.sample_valid_out && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    if (!bus.sample_valid_out) chk({nm, "_valid_timeout"}, 0, 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_rd_addr"}, bus.bram_rd_addr, 0);
    chk({nm, "_wr_addr"}, bus.bram_wr_addr, 0);
    chk({nm, "_wr_en"}, bus.bram_wr_en, 0);
    chk({nm, "_sample"}, bus.sample_out, 0);
    chk({nm, "_valid"}, bus.sample_valid_out, 0);
    chk({nm, "_busy"}, bus.busy_out, 0);
    chk({nm, "_done"}, bus.done_out, 0);
    chk({nm, "_overrun"}, bus.overrun_out, 0);
  endtask

  int cleared_ok;

  initial begin
    bus.window_len_in       = '0;
    bus.window_len_valid_in = 1'b0;
    bus.sample_ready_in     = 1'b1;

    // Model sanity against hand-computed values
    chk("model_pos", model(32'h00000BFF), 2);
    chk("model_neg", model(32'hFFFFFC00), -1);
    chk("model_sat", model(32'h02000000), 32767);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill the whole buffer with a varied signed pattern
    for (int i = 0; i < DEPTH; i++) load(i, 32'(i * 7919 - 8000000));

    // Clamp: 4000 -> 2200 samples, last clear at 2199
    arm(4000);
    pulse(4000);
    wait_done("clamp", 10000);
    chk("clamp_last_addr", last_wr, 2199);
    cleared_ok = 1;
    for (int i = 0; i < DEPTH; i++) if (mem[i] != 32'd0) cleared_ok = 0;
    chk("clamp_buffer_cleared", cleared_ok, 1);

    // Basic drain
    load(0, 32'h00000400); load(1, 32'hFFFFFC00); load(2, 32'h00000BFF);
    arm(3);
    pulse(3);
    wait_done("basic", 100);
    chk("basic_first_valid_cycle", first_vld - start_cyc, 4);
    chk("basic_done_cycle", done_cyc - start_cyc, 13);
    chk("basic_s0", got_q.size() > 0 ? got_q[0] : 999, 1);
    chk("basic_s1", got_q.size() > 1 ? got_q[1] : 999, -1);
    chk("basic_s2", got_q.size() > 2 ? got_q[2] : 999, 2);
    chk("basic_last_addr", last_wr, 2);

    // Saturation and rounding
    load(0, 32'h02000000); load(1, 32'hFE000000); load(2, 32'hFFFFFFFF);
    arm(3);
    pulse(3);
    wait_done("sat", 100);
    chk("sat_s0", got_q.size() > 0 ? got_q[0] : 999, 32767);
    chk("sat_s1", got_q.size() > 1 ? got_q[1] : 999, -32768);
    chk("sat_s2", got_q.size() > 2 ? got_q[2] : 999, -1);

    // Backpressure: hold ready low 5 cycles on the first sample
    load(0, 32'h00012345); load(1, 32'hFFF00000); load(2, 32'h00000000);
    arm(3);
    bus.sample_ready_in = 1'b0;
    pulse(3);
    wait_valid("bp", 20);
    @(posedge clk); #1;
    repeat (5) begin
      chk("bp_no_clear_while_held", bus.bram_wr_en, 0);
      @(posedge clk); #1;
    end
    bus.sample_ready_in = 1'b1;
    wait_done("bp", 100);

    // Zero length: done next cycle, nothing read
    arm(0);
    pulse(0);
    wait_done("zero", 20);
    chk("zero_done_cycle", done_cyc - start_cyc, 1);
    chk("zero_no_busy", busy_seen, 0);

    // Overrun while sample 1 of 3 is presented
    load(0, 32'h00000800); load(1, 32'h00001000); load(2, 32'hFFFFF000);
    arm(3);
    bus.sample_ready_in = 1'b0;
    pulse(3);
    wait_valid("ovr", 20);
    @(posedge clk); #1;
    bus.window_len_in       = 12'd5;
    bus.window_len_valid_in = 1'b1;
    @(posedge clk); #1;
    bus.window_len_valid_in = 1'b0;
    chk("ovr_pulse", bus.overrun_out, 1);
    @(posedge clk); #1;
    chk("ovr_single_cycle", bus.overrun_out, 0);
    bus.sample_ready_in = 1'b1;
    wait_done("ovr", 100);
    chk("ovr_count", n_ovr, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("ovr_no_restart", n_samples, 3);

    // Reset mid-drain while sample 2 of 5 is presented
    for (int i = 0; i < 5; i++) load(i, 32'(32'h00000400 * (i + 1)));
    arm(5);
    pulse(5);
    begin
      int i;
      i = 0;
      while (n_samples < 1 && i < 50) begin
        @(negedge clk); #1;
        i++;
      end
    end
    @(posedge clk); #1;
    bus.sample_ready_in = 1'b0;
    wait_valid("rst", 20);
    rst    = 1'b1;
    chk_en = 0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    bus.sample_ready_in = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_done", n_done, 0);
    chk("midrst_sample_count", n_samples, 1);
    chk("midrst_addr1_kept", mem[1], 32'h00000800);
    chk("midrst_addr4_kept", mem[4], 32'h00001400);
    load(0, 32'h00002C00); load(1, 32'hFFFFD400);
    arm(2);
    pulse(2);
    wait_done("after_rst", 100);
    chk("after_rst_first_valid", first_vld - start_cyc, 4);
    chk("after_rst_s0", got_q.size() > 0 ? got_q[0] : 999, 11);
    chk("after_rst_s1", got_q.size() > 1 ? got_q[1] : 999, -11);
    chk("after_rst_last_addr", last_wr, 1);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/psola_readout.md
Name: psola_readout

Overview:
- Drains the PSOLA overlap-add accumulation buffer once a pitch-shifted window is complete.
- Started by the PSOLA stage's window length/valid pair. Reads addresses 0..window_len-1 of the 32-bit processed BRAM.
- Removes the Q10 window gain, saturates each value to 16-bit PCM and presents it on a valid/ready stream to the audio output path.
- Zeroes each location after it is consumed, so the buffer is clean for the next window's accumulation.

Parameters:
- MAX_EXTENDED, 2200, depth of the processed buffer; address width AW = $clog2(MAX_EXTENDED).
- GAIN_SHIFT, 10, arithmetic right shift that removes the window-function fixed-point gain.
- READ_LATENCY, 2, BRAM read latency in cycles from address to data.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- window_len_in  input  12  number of valid samples in the processed buffer
- window_len_valid_in  input  1  single-cycle pulse; window_len_in is valid this cycle
- bram_rd_addr  output  AW  read address to the processed BRAM
- bram_rd_data  input  32  signed data for the address driven READ_LATENCY cycles earlier
- bram_wr_addr  output  AW  clear-write address
- bram_wr_data  output  32  clear-write data, constant 0
- bram_wr_en  output  1  clear-write strobe
- sample_out  output  16  signed PCM sample
- sample_valid_out  output  1  sample_out valid
- sample_ready_in  input  1  downstream accepts the sample
- busy_out  output  1  a window is being drained
- done_out  output  1  one-cycle pulse when drain completes
- overrun_out  output  1  one-cycle pulse when window_len_valid_in arrives while busy

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset values:
  - State IDLE; counter k=0; len=0.
  - bram_rd_addr=0, bram_wr_addr=0, bram_wr_en=0.
  - sample_out=0, sample_valid_out=0.
  - busy_out=0, done_out=0, overrun_out=0.
  - bram_wr_data is always 0.
- Reset mid-drain: abandon the drain. Remaining locations are not cleared, and no done_out is issued.
- IDLE:
  - On window_len_valid_in, latch len = min(window_len_in, MAX_EXTENDED) and set k=0.
  - If len==0: pulse done_out next cycle and stay IDLE.
  - Otherwise go to FETCH and set busy_out=1.
- FETCH (1 cycle): drive bram_rd_addr=k, then go to WAIT.
- WAIT: count READ_LATENCY cycles. On the cycle bram_rd_data is valid for address k:
  - register sample_out = sat16(bram_rd_data >>> GAIN_SHIFT);
  - set sample_valid_out=1 and go to PRESENT.
- Sample arithmetic:
  - The shift is arithmetic, truncating toward negative infinity.
  - sat16 clamps to the range [-32768, 32767].
- PRESENT:
  - Hold sample_out and sample_valid_out stable until sample_ready_in=1. No sample is dropped or duplicated.
  - On the handshake cycle, next cycle: sample_valid_out=0 and bram_wr_en=1 for exactly one cycle with bram_wr_addr=k.
  - If k==len-1: go IDLE, busy_out=0, done_out=1 for one cycle (coincident with the final clear write).
  - Otherwise k=k+1 and go to FETCH.
- Timing:
  - window_len_valid_in at cycle 0 gives bram_rd_addr=0 at cycle 1 and sample_valid_out=1 at cycle 4 (READ_LATENCY=2).
  - With ready held high, each sample takes 4 cycles.
- window_len_valid_in while busy:
  - The pulse is ignored and the current drain continues unchanged.
  - overrun_out pulses one cycle.
  - This includes the done cycle, which still counts as busy.
- No address above len-1 is ever read or written. The clear write and the next read address may coincide in the same cycle; the BRAM is true dual-port.

Test Plan:
- Basic drain: buffer {0x00000400, 0xFFFFFC00, 0x00000BFF}, window_len=3, ready held high -> samples 1, -1, 2; addresses 0..2 written 0 in order; done_out once; first sample_valid_out at cycle 4.
- Saturation and rounding: buffer {0x02000000, 0xFE000000, 0xFFFFFFFF} -> 32767, -32768, -1.
- Backpressure: ready low for 5 cycles while a sample is presented -> sample_out stable throughout; the clear write occurs only after the handshake; sample count equals len.
- Zero and clamp: window_len=0 -> no reads, done_out on the next cycle. window_len=4000 -> exactly 2200 samples, last address 2199.
- Overrun: second window_len_valid_in while sample 1 of 3 is presented -> overrun_out pulses; exactly 3 samples; no restart.
- Reset mid-drain at sample 2 of 5 -> all outputs return to reset values next cycle; a new window_len=2 afterwards drains normally from address 0.
